// File: rtl/double_buffer.sv
// Ping-pong line buffer: a built-in pattern generator fills the back line while the front line is scanned out.
// Optional macro DBUF_GRID_EN overlays an all-ones grid on every 8th pixel column and line.
module double_buffer #(
  parameter  int WIDTH       = 64,
  parameter  int HEIGHT      = 48,
  parameter  int PIXEL_SIZE  = 8,
  localparam int PACKED_SIZE = WIDTH * PIXEL_SIZE,
  localparam int LW          = $clog2(HEIGHT)
) (
  input  logic                   clk,
  input  logic                   resetn,
  output logic [PACKED_SIZE-1:0] packed_buffer,
  output logic [LW:0]            hline_sel
);

  localparam int XW = $clog2(WIDTH);

  logic [PACKED_SIZE-1:0] r_buf_a;
  logic [PACKED_SIZE-1:0] r_buf_b;
  logic                   r_sel;
  logic [XW-1:0]          r_wr_x;
  logic [LW-1:0]          r_gen_line;
  logic [LW-1:0]          r_index;
  logic                   r_valid;
  logic [PIXEL_SIZE-1:0]  w_pix;

  function automatic logic [PIXEL_SIZE-1:0] f_pix(input logic [XW-1:0] x, input logic [LW-1:0] l);
    logic [31:0] sum;
    sum = 32'(x) + 32'(l);
`ifdef DBUF_GRID_EN
    if ((32'(x) % 32'd8 == 32'd0) || (32'(l) % 32'd8 == 32'd0)) begin
      sum = '1;
    end
`endif
    return sum[PIXEL_SIZE-1:0];
  endfunction

  always_comb begin
    w_pix = f_pix(r_wr_x, r_gen_line);
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      r_buf_a    <= '0;
      r_buf_b    <= '0;
      r_sel      <= 1'b0;
      r_wr_x     <= '0;
      r_gen_line <= '0;
      r_index    <= '0;
      r_valid    <= 1'b0;
    end else begin
      // Only the back buffer (the one not selected for scan-out) is ever written.
      if (r_sel) begin
        r_buf_a[int'(r_wr_x)*PIXEL_SIZE +: PIXEL_SIZE] <= w_pix;
      end else begin
        r_buf_b[int'(r_wr_x)*PIXEL_SIZE +: PIXEL_SIZE] <= w_pix;
      end
      if (r_wr_x == XW'(WIDTH - 1)) begin
        r_sel      <= ~r_sel;
        r_wr_x     <= '0;
        r_index    <= r_gen_line;
        r_valid    <= 1'b1;
        r_gen_line <= (r_gen_line == LW'(HEIGHT - 1)) ? '0 : r_gen_line + 1'b1;
      end else begin
        r_wr_x <= r_wr_x + 1'b1;
      end
    end
  end

  assign packed_buffer = r_sel ? r_buf_b : r_buf_a;
  assign hline_sel     = {r_valid, r_index};

endmodule

// File: tb/tb_double_buffer.sv
// Scoreboard bench for double_buffer: expected outputs come from a cycle-count model of the line sequence.
module tb_double_buffer;

  localparam int W  = 64;
  localparam int H  = 48;
  localparam int P  = 8;
  localparam int PK = W * P;
  localparam int LW = $clog2(H);

  logic          clk;
  logic          resetn;
  logic [PK-1:0] packed_buffer;
  logic [LW:0]   hline_sel;

  double_buffer #(.WIDTH(W), .HEIGHT(H), .PIXEL_SIZE(P)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .packed_buffer(packed_buffer),
    .hline_sel    (hline_sel)
  );

  initial clk = 1'b0;
  always #100 clk = ~clk;

  logic [PK-1:0] q_pb[$];
  logic [LW:0]   q_hs[$];
  string         q_tag[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc    = 0;   // non-reset edges since last reset
  string         tag    = "reset";

  // Expected front line after 'c' non-reset edges: nothing valid until the first full line,
  // then line (c/W - 1) mod H is on display.
  task automatic model(input int c, output logic [PK-1:0] pb, output logic [LW:0] hs);
    int line;
    int v;
    pb = '0;
    hs = '0;
    if (c >= W) begin
      line = (c / W - 1) % H;
      hs = {1'b1, LW'(line)};
      for (int j = 0; j < W; j++) begin
        v = (j + line) % 256;
`ifdef DBUF_GRID_EN
        if (j % 8 == 0 || line % 8 == 0) v = 255;
`endif
        pb[j*P +: P] = P'(v);
      end
    end
  endtask

  task automatic step(input logic rst);
    logic [PK-1:0] pb;
    logic [LW:0]   hs;
    @(negedge clk);
    resetn = rst;
    @(posedge clk);
    if (rst) cyc = 0;
    else cyc = cyc + 1;
    model(cyc, pb, hs);
    q_pb.push_back(pb);
    q_hs.push_back(hs);
    q_tag.push_back(tag);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  always @(negedge clk) begin
    if (q_pb.size() > 0) begin
      logic [PK-1:0] epb;
      logic [LW:0]   ehs;
      string         et;
      epb = q_pb.pop_front();
      ehs = q_hs.pop_front();
      et  = q_tag.pop_front();
      checks = checks + 1;
      if (hline_sel !== ehs) begin
        errors = errors + 1;
        $display("FAIL %s hline_sel got %h want %h (cyc %0d)", et, hline_sel, ehs, cyc);
      end
      checks = checks + 1;
      if (packed_buffer !== epb) begin
        errors = errors + 1;
        $display("FAIL %s packed_buffer got %h want %h", et, packed_buffer, epb);
      end
    end
  end

  initial begin
    resetn = 1'b1;
    tag = "reset";
    for (int i = 0; i < 3; i++) step(1'b1);
    tag = "first_lines";
    run(2 * W + 10);
    tag = "wrap";
    run(H * W);
    tag = "midline_reset";
    run(W - 10 + 30);
    step(1'b1);
    tag = "after_reset";
    run(W + 5);
    tag = "random";
    for (int k = 0; k < 6; k++) begin
      run($urandom_range(W * 4, 1));
      for (int r = $urandom_range(3, 1); r > 0; r--) step(1'b1);
    end
    run(W * 3);
    repeat (3) @(negedge clk);
    checks = checks + 1;
    if (q_pb.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain queue got %0d want 0", q_pb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
